xrs: RTL and testbench

XRS -- requirements
Module: xrs

---
 rtl/xrs_pkg.sv | 37 +++
 rtl/xrs_ext.sv | 35 +++
 rtl/xrs.sv | 85 ++++++++
 tb/tb_xrs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xrs_pkg.sv
// Shared widths and the write-extension mode type for the XRS register file.
// The same-cycle write-to-read bypass is built only when XRS_BYPASS_EN is defined.
package xrs_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    typedef enum logic [2:0] {
        NONE,
        SX8,
        SX16,
        SX32,
        SX64,
        ZX8,
        ZX16,
        ZX32
    } ext_mode_e;

    // Widen the low bits of d according to the selected extension mode.
    function automatic logic [XLEN-1:0] extend(input ext_mode_e mode, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        r = '0;
        case (mode)
            SX8:     r = {{56{d[7]}}, d[7:0]};
            SX16:    r = {{48{d[15]}}, d[15:0]};
            SX32:    r = {{32{d[31]}}, d[31:0]};
            SX64:    r = d;
            ZX8:     r = {56'd0, d[7:0]};
            ZX16:    r = {48'd0, d[15:0]};
            ZX32:    r = {32'd0, d[31:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xrs_ext.sv
// Write-strobe priority encoder and extension datapath for the XRS register file.
// Purely combinational; produces a write enable and the widened write data.
module xrs_ext
    import xrs_pkg::*;
(
    input  logic            sx8,
    input  logic            sx16,
    input  logic            sx32,
    input  logic            sx64,
    input  logic            zx8,
    input  logic            zx16,
    input  logic            zx32,
    input  logic [XLEN-1:0] din,
    output logic            we,
    output logic [XLEN-1:0] wdata
);

    ext_mode_e mode;

    // Wider sign-extending strobes win, then zero-extending ones from widest down.
    always_comb begin
        mode = NONE;
        if (sx64)       mode = SX64;
        else if (sx32)  mode = SX32;
        else if (sx16)  mode = SX16;
        else if (sx8)   mode = SX8;
        else if (zx32)  mode = ZX32;
        else if (zx16)  mode = ZX16;
        else if (zx8)   mode = ZX8;
    end

    assign we    = (mode != NONE);
    assign wdata = extend(mode, din);

endmodule

// File: rtl/xrs.sv
// XRS: 32 x 64-bit register file, one extending write port, two registered read ports.
// Define XRS_BYPASS_EN to forward same-cycle write data to a matching read index.
module xrs
    import xrs_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [XLEN-1:0]   rdat_i,
    input  logic              rsx8_i,
    input  logic              rsx16_i,
    input  logic              rsx32_i,
    input  logic              rsx64_i,
    input  logic              rzx8_i,
    input  logic              rzx16_i,
    input  logic              rzx32_i,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    output logic [XLEN-1:0]   rdata_o,
    output logic [XLEN-1:0]   rdatb_o
);

    logic [XLEN-1:0] regs [NREGS];

    logic            ext_we;
    logic [XLEN-1:0] ext_wdata;
    logic            wr_en;

    xrs_ext u_ext (
        .sx8   (rsx8_i),
        .sx16  (rsx16_i),
        .sx32  (rsx32_i),
        .sx64  (rsx64_i),
        .zx8   (rzx8_i),
        .zx16  (rzx16_i),
        .zx32  (rzx32_i),
        .din   (rdat_i),
        .we    (ext_we),
        .wdata (ext_wdata)
    );

    // x0 is never stored; reset swallows any write issued in the same cycle.
    assign wr_en = ext_we && !reset_i && (rd_i != '0);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            regs[rd_i] <= ext_wdata;
        end
    end

    logic [1:0][REG_AW-1:0] raddr;
    assign raddr[0] = ra_i;
    assign raddr[1] = rb_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            logic [XLEN-1:0] rdat_next;
            logic [XLEN-1:0] rdat_reg;

            always_comb begin
                rdat_next = regs[raddr[gi]];
                if (raddr[gi] == '0) begin
                    rdat_next = '0;
                end
`ifdef XRS_BYPASS_EN
                else if (wr_en && (raddr[gi] == rd_i)) begin
                    rdat_next = ext_wdata;
                end
`endif
            end

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    rdat_reg <= '0;
                end else begin
                    rdat_reg <= rdat_next;
                end
            end
        end
    endgenerate

    assign rdata_o = g_rport[0].rdat_reg;
    assign rdatb_o = g_rport[1].rdat_reg;

endmodule

// File: tb/tb_xrs.sv
// Scoreboard bench for xrs: directed vectors with fixed expectations plus random traffic
// predicted by an array-based reference model; a monitor pops and compares each cycle.
module tb_xrs;
    import xrs_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [4:0]  rd_i, ra_i, rb_i;
    logic [63:0] rdat_i;
    logic        rsx8_i, rsx16_i, rsx32_i, rsx64_i, rzx8_i, rzx16_i, rzx32_i;
    logic [63:0] rdata_o, rdatb_o;

    always #5 clk = ~clk;

    xrs dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .rd_i    (rd_i),
        .rdat_i  (rdat_i),
        .rsx8_i  (rsx8_i),
        .rsx16_i (rsx16_i),
        .rsx32_i (rsx32_i),
        .rsx64_i (rsx64_i),
        .rzx8_i  (rzx8_i),
        .rzx16_i (rzx16_i),
        .rzx32_i (rzx32_i),
        .ra_i    (ra_i),
        .rb_i    (rb_i),
        .rdata_o (rdata_o),
        .rdatb_o (rdatb_o)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        bit          chk_a;
        bit          chk_b;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [32];
    bit          known [32];
    int          errors = 0;
    int          checks = 0;

    // Strobe vector bit order: {sx64, sx32, sx16, sx8, zx32, zx16, zx8}.
    localparam logic [6:0] S_SX64 = 7'b1000000;
    localparam logic [6:0] S_SX32 = 7'b0100000;
    localparam logic [6:0] S_SX16 = 7'b0010000;
    localparam logic [6:0] S_SX8  = 7'b0001000;
    localparam logic [6:0] S_ZX32 = 7'b0000100;
    localparam logic [6:0] S_ZX16 = 7'b0000010;
    localparam logic [6:0] S_ZX8  = 7'b0000001;

    function automatic logic [63:0] ext_model(input logic [6:0] s, input logic [63:0] d);
        if (s[6]) return d;
        if (s[5]) return 64'($signed(d[31:0]));
        if (s[4]) return 64'($signed(d[15:0]));
        if (s[3]) return 64'($signed(d[7:0]));
        if (s[2]) return 64'(d[31:0]);
        if (s[1]) return 64'(d[15:0]);
        return 64'(d[7:0]);
    endfunction

    // Value a read port should present after this edge, from the model's point of view.
    task automatic predict(input logic [4:0] idx, input logic [6:0] s, input logic [4:0] rd,
                           input logic [63:0] d, input bit rst,
                           output logic [63:0] val, output bit ok);
        val = 64'd0;
        ok  = 1'b1;
        if (rst || idx == 5'd0) begin
            val = 64'd0;
        end
`ifdef XRS_BYPASS_EN
        else if (s != 7'd0 && rd != 5'd0 && idx == rd) begin
            val = ext_model(s, d);
        end
`endif
        else begin
            val = model[idx];
            ok  = known[idx];
        end
    endtask

    task automatic step(input logic [6:0] s, input logic [4:0] rd, input logic [63:0] d,
                        input logic [4:0] a, input logic [4:0] b, input bit rst,
                        input bit use_c, input logic [63:0] ca, input logic [63:0] cb,
                        input string tag);
        exp_t e;
        @(negedge clk);
        reset_i = rst;
        rd_i    = rd;
        rdat_i  = d;
        {rsx64_i, rsx32_i, rsx16_i, rsx8_i, rzx32_i, rzx16_i, rzx8_i} = s;
        ra_i = a;
        rb_i = b;
        e.tag = tag;
        if (use_c) begin
            e.a = ca; e.b = cb; e.chk_a = 1'b1; e.chk_b = 1'b1;
        end else begin
            predict(a, s, rd, d, rst, e.a, e.chk_a);
            predict(b, s, rd, d, rst, e.b, e.chk_b);
        end
        sb.push_back(e);
        if (!rst && s != 7'd0 && rd != 5'd0) begin
            model[rd] = ext_model(s, d);
            known[rd] = 1'b1;
        end
    endtask

    task automatic wr(input logic [6:0] s, input logic [4:0] rd, input logic [63:0] d);
        step(s, rd, d, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, "write");
    endtask

    task automatic rdc(input logic [4:0] a, input logic [4:0] b,
                       input logic [63:0] ca, input logic [63:0] cb, input string tag);
        step(7'd0, 5'd0, 64'd0, a, b, 1'b0, 1'b1, ca, cb, tag);
    endtask

    // Monitor: every edge that had stimulus behind it produces one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_a) begin
                    checks++;
                    if (rdata_o !== e.a) begin
                        errors++;
                        $display("FAIL %s portA: got %h expected %h", e.tag, rdata_o, e.a);
                    end
                end
                if (e.chk_b) begin
                    checks++;
                    if (rdatb_o !== e.b) begin
                        errors++;
                        $display("FAIL %s portB: got %h expected %h", e.tag, rdatb_o, e.b);
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] new5;
        logic [63:0] dr;
        logic [6:0]  sr;
        int          waited;

        for (int i = 0; i < 32; i++) begin
            model[i] = 64'd0;
            known[i] = (i == 0);
        end
        reset_i = 1'b1; rd_i = '0; rdat_i = '0; ra_i = '0; rb_i = '0;
        {rsx64_i, rsx32_i, rsx16_i, rsx8_i, rzx32_i, rzx16_i, rzx8_i} = 7'd0;

        step(7'd0, 5'd0, 64'd0, 5'd3, 5'd7, 1'b1, 1'b1, 64'd0, 64'd0, "reset_state");
        step(7'd0, 5'd0, 64'd0, 5'd3, 5'd7, 1'b1, 1'b1, 64'd0, 64'd0, "reset_state");

        for (int i = 1; i < 32; i++) begin
            wr(S_SX64, 5'(i), {$urandom, $urandom});
        end

        wr(S_SX64, 5'd1, 64'h1122334455667788);
        wr(S_SX64, 5'd2, 64'h7766554433221100);
        rdc(5'd1, 5'd2, 64'h1122334455667788, 64'h7766554433221100, "basic_ab");
        rdc(5'd2, 5'd1, 64'h7766554433221100, 64'h1122334455667788, "basic_swap");
        rdc(5'd2, 5'd2, 64'h7766554433221100, 64'h7766554433221100, "same_index");

        wr(S_SX64, 5'd0, 64'hFFFFFFFFFFFFFFFF);
        rdc(5'd0, 5'd0, 64'd0, 64'd0, "x0_zero");

        wr(S_SX8,  5'd3, 64'h7766554433221100);
        wr(S_SX16, 5'd4, 64'h7766554433221100);
        wr(S_SX32, 5'd5, 64'h7766554433221100);
        wr(S_SX64, 5'd6, 64'h7766554433221100);
        rdc(5'd3, 5'd4, 64'h0, 64'h1100, "sx_pos_8_16");
        rdc(5'd5, 5'd6, 64'h33221100, 64'h7766554433221100, "sx_pos_32_64");

        wr(S_SX8,  5'd3, 64'h8766554483228180);
        wr(S_SX16, 5'd4, 64'h8766554483228180);
        wr(S_SX32, 5'd5, 64'h8766554483228180);
        wr(S_SX64, 5'd6, 64'h8766554483228180);
        rdc(5'd3, 5'd4, 64'hFFFFFFFFFFFFFF80, 64'hFFFFFFFFFFFF8180, "sx_neg_8_16");
        rdc(5'd5, 5'd6, 64'hFFFFFFFF83228180, 64'h8766554483228180, "sx_neg_32_64");

        wr(S_ZX8,  5'd7,  64'hFFFFFFFFFFFFFFFF);
        wr(S_ZX16, 5'd8,  64'hFFFFFFFFFFFFFFFF);
        wr(S_ZX32, 5'd9,  64'hFFFFFFFFFFFFFFFF);
        wr(S_SX8 | S_ZX32, 5'd10, 64'hFFFFFFFFFFFFFFFF);
        rdc(5'd7, 5'd8, 64'hFF, 64'hFFFF, "zx_8_16");
        rdc(5'd9, 5'd10, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, "zx32_prio");

        wr(S_SX64, 5'd11, 64'h0123456789ABCDEF);
        step(S_SX64, 5'd11, 64'h5555AAAA5555AAAA, 5'd11, 5'd11, 1'b1, 1'b1, 64'd0, 64'd0, "reset_wr");
        rdc(5'd11, 5'd0, 64'h0123456789ABCDEF, 64'd0, "reset_kept");

        new5 = 64'hDEADBEEF00000001;
`ifdef XRS_BYPASS_EN
        step(S_SX64, 5'd5, new5, 5'd5, 5'd5, 1'b0, 1'b1, new5, new5, "rdw_x5");
`else
        step(S_SX64, 5'd5, new5, 5'd5, 5'd5, 1'b0, 1'b1,
             64'hFFFFFFFF83228180, 64'hFFFFFFFF83228180, "rdw_x5");
`endif
        rdc(5'd5, 5'd4, new5, 64'hFFFFFFFFFFFF8180, "rdw_after");

        for (int n = 0; n < 400; n++) begin
            sr = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
            case ($urandom_range(0, 3))
                0:       dr = 64'hFFFFFFFFFFFFFFFF ^ 64'($urandom);
                1:       dr = 64'($urandom);
                default: dr = {$urandom, $urandom};
            endcase
            step(sr, 5'($urandom), dr, 5'($urandom), 5'($urandom),
                 ($urandom_range(0, 31) == 0), 1'b0, 64'd0, 64'd0, "random");
        end

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
